// File: rtl/rr_grant_sched.sv
// ============================================================================
//  rr_grant_sched : round-robin owner for a shared engine, hold timeout + gap
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_grant_sched #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = $clog2(N),
   parameter int CW       = $clog2(MAX_HOLD + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_i,
   input  logic           release_i,
   output logic [N-1:0]   grant_o,
   output logic [IDW-1:0] grant_id_o,
   output logic           busy_o,
   output logic           timeout_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_GAP    = 2'd2
   } state_t;

   state_t         state_q,      state_d;
   logic [N-1:0]   grant_q,      grant_d;
   logic [IDW-1:0] grant_id_q,   grant_id_d;
   logic [IDW-1:0] last_owner_q, last_owner_d;
   logic [CW-1:0]  hold_cnt_q,   hold_cnt_d;
   logic           timeout_q,    timeout_d;

   logic [IDW-1:0] sel_id;
   logic           sel_found;
   logic [IDW-1:0] scan_idx;
   logic           owner_req;
   logic           at_limit;

   // Scan starts just past the previous owner so it gets lowest priority.
   always_comb begin
      sel_id    = '0;
      sel_found = 1'b0;
      scan_idx  = '0;
      for (int k = 1; k <= N; k++) begin
         scan_idx = IDW'((int'(last_owner_q) + k) % N);
         if (!sel_found && req_i[scan_idx]) begin
            sel_id    = scan_idx;
            sel_found = 1'b1;
         end
      end
   end

   assign owner_req = req_i[grant_id_q];
   assign at_limit  = (hold_cnt_q == CW'(MAX_HOLD));

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      grant_id_d   = grant_id_q;
      last_owner_d = last_owner_q;
      hold_cnt_d   = hold_cnt_q;
      timeout_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               state_d    = S_ACTIVE;
               grant_d    = {{(N-1){1'b0}}, 1'b1} << sel_id;
               grant_id_d = sel_id;
               hold_cnt_d = CW'(1);
            end
         end
         S_ACTIVE: begin
            if (release_i || !owner_req || at_limit) begin
               state_d      = S_GAP;
               grant_d      = '0;
               last_owner_d = grant_id_q;
               hold_cnt_d   = '0;
               // A voluntary end on the last allowed cycle is not a timeout.
               timeout_d    = at_limit && !release_i && owner_req;
            end else begin
               hold_cnt_d = hold_cnt_q + CW'(1);
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         grant_id_q   <= '0;
         last_owner_q <= IDW'(N - 1);
         hold_cnt_q   <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         grant_id_q   <= grant_id_d;
         last_owner_q <= last_owner_d;
         hold_cnt_q   <= hold_cnt_d;
         timeout_q    <= timeout_d;
      end
   end

   assign grant_o    = grant_q;
   assign grant_id_o = grant_id_q;
   assign busy_o     = (state_q != S_IDLE);
   assign timeout_o  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_sched.sv
// ============================================================================
//  tb_rr_grant_sched : scoreboard bench for rr_grant_sched
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rr_grant_sched;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;
   localparam int IDW      = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_i = '0;
   logic           release_i = 1'b0;
   logic [N-1:0]   grant_o;
   logic [IDW-1:0] grant_id_o;
   logic           busy_o;
   logic           timeout_o;

   always #5 clk = ~clk;

   rr_grant_sched #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .release_i  (release_i),
      .grant_o    (grant_o),
      .grant_id_o (grant_id_o),
      .busy_o     (busy_o),
      .timeout_o  (timeout_o)
   );

   typedef struct packed {
      logic [N-1:0]   g;
      logic [IDW-1:0] id;
      logic           b;
      logic           t;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: owner index (-1 = none), cycles held, pending gap cycle
   int m_owner = -1;
   int m_held  = 0;
   int m_last  = N - 1;
   int m_id    = 0;
   bit m_skip  = 1'b0;
   bit m_to    = 1'b0;

   int obs_ids[$];
   int obs_len[$];
   int obs_gap[$];
   int obs_to = 0;
   int rel_at = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int id_at(input int k);
      return (k < obs_ids.size()) ? obs_ids[k] : 99;
   endfunction
   function automatic int len_at(input int k);
      return (k < obs_len.size()) ? obs_len[k] : 99;
   endfunction
   function automatic int gap_at(input int k);
      return (k < obs_gap.size()) ? obs_gap[k] : 99;
   endfunction

   task automatic model_step();
      exp_t e;
      bit   found;
      int   c;
      if (rst) begin
         m_owner = -1; m_held = 0; m_last = N - 1; m_id = 0; m_skip = 1'b0; m_to = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_owner >= 0) begin
            if (release_i || !req_i[m_owner] || m_held == MAX_HOLD) begin
               m_to    = !release_i && req_i[m_owner];
               m_last  = m_owner;
               m_owner = -1;
               m_skip  = 1'b1;
            end else begin
               m_held++;
            end
         end else if (m_skip) begin
            m_skip = 1'b0;
         end else if (req_i != '0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               c = (m_last + k) % N;
               if (!found && req_i[c]) begin
                  m_owner = c;
                  found   = 1'b1;
               end
            end
            m_held = 1;
            m_id   = m_owner;
         end
      end
      e.g  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e.id = IDW'(m_id);
      e.b  = (m_owner >= 0) || m_skip;
      e.t  = m_to;
      sb_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: pops one expectation per cycle and logs tenure shape
   initial begin
      exp_t         e;
      logic [N-1:0] prev_g;
      int           cur_len;
      int           cur_gap;
      bit           seen;
      prev_g = '0; cur_len = 0; cur_gap = 0; seen = 1'b0;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("grant", grant_o, e.g);
            check("busy", busy_o, e.b);
            check("timeout", timeout_o, e.t);
            check("onehot0", $onehot0(grant_o), 1);
            if (e.g != '0) check("grant_id", grant_id_o, e.id);
         end
         if (rst) seen = 1'b0;
         if (timeout_o) obs_to++;
         if (grant_o != '0) begin
            if (prev_g == '0) begin
               obs_ids.push_back(int'(grant_id_o));
               if (seen) obs_gap.push_back(cur_gap);
               cur_len = 0;
            end
            cur_len++;
         end else begin
            if (prev_g != '0) begin
               obs_len.push_back(cur_len);
               cur_gap = 0;
               seen    = 1'b1;
            end
            cur_gap++;
         end
         prev_g = grant_o;
      end
   end

   task automatic run(input logic [N-1:0] r, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         req_i     = r;
         release_i = (m_owner >= 0) && (m_held == rel_at);
      end
      #1;
   endtask

   task automatic clear_obs();
      obs_ids.delete();
      obs_len.delete();
      obs_gap.delete();
      obs_to = 0;
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      req_i     = '0;
      release_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      check({tag, "_async_grant"}, grant_o, 0);
      check({tag, "_async_busy"}, busy_o, 0);
      check({tag, "_async_timeout"}, timeout_o, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_obs();
   endtask

   initial begin
      logic [N-1:0] r;
      int           hold;

      repeat (2) @(negedge clk);
      #1;
      check("rst_grant", grant_o, 0);
      check("rst_grant_id", grant_id_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_timeout", timeout_o, 0);
      @(negedge clk);
      rst = 1'b0;
      clear_obs();

      // Single requester, released on its 3rd grant cycle
      rel_at = 3;
      run(4'b0001, 12);
      check("s1_id0", id_at(0), 0);
      check("s1_id1", id_at(1), 0);
      check("s1_len", len_at(0), 3);
      check("s1_gap", gap_at(0), 2);
      check("s1_no_timeout", obs_to, 0);

      // All requesting, released on 2nd cycle: strict rotation
      apply_reset("s2");
      rel_at = 2;
      run(4'b1111, 22);
      check("s2_id0", id_at(0), 0);
      check("s2_id1", id_at(1), 1);
      check("s2_id2", id_at(2), 2);
      check("s2_id3", id_at(3), 3);
      check("s2_id4", id_at(4), 0);
      check("s2_len", len_at(0), 2);
      check("s2_gap", gap_at(0), 2);

      // Hold until MAX_HOLD: timeout pulse
      apply_reset("s3");
      rel_at = 0;
      run(4'b0010, 14);
      check("s3_id", id_at(0), 1);
      check("s3_len", len_at(0), MAX_HOLD);
      check("s3_timeout", obs_to, 1);

      // Release on the final allowed cycle: no timeout
      apply_reset("s4");
      rel_at = MAX_HOLD;
      run(4'b0010, 14);
      check("s4_len", len_at(0), MAX_HOLD);
      check("s4_no_timeout", obs_to, 0);

      // Owner 2 withdraws with 0 and 3 waiting: 3 wins
      apply_reset("s5");
      rel_at = 0;
      run(4'b0100, 3);
      run(4'b1001, 8);
      check("s5_id0", id_at(0), 2);
      check("s5_id1", id_at(1), 3);
      check("s5_len", len_at(0), 3);

      // Asynchronous reset while 2 owns the engine
      apply_reset("s6a");
      run(4'b0100, 3);
      check("s6_pre_grant", grant_o, 4'b0100);
      apply_reset("s6b");
      run(4'b1111, 4);
      check("s6_first_id", id_at(0), 0);

      // Randomized traffic against the model
      rel_at = 0;
      for (int i = 0; i < 200; i++) begin
         r    = N'($urandom);
         hold = $urandom_range(1, 6);
         for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            req_i     = r;
            release_i = ($urandom_range(0, 4) == 0);
         end
      end
      repeat (3) @(negedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
